// File: rtl/cluster_count_monitor_pkg.sv
// rtl/cluster_count_monitor_pkg.sv - parameter defaults and FSM state type for the cluster count monitor
package cluster_count_monitor_pkg;

  localparam int CNT_W_DEF      = 11;
  localparam int OVF_THRESH_DEF = 8;
  localparam int WIN_LOG2_DEF   = 10;
  localparam int OVFCNT_W_DEF   = 16;
  localparam int DROP_W_DEF     = 8;
  localparam int SUM_W_DEF      = CNT_W_DEF + WIN_LOG2_DEF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with dominant synchronous clear
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // count events, hold at all-ones, clear wins over a same-cycle increment
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cluster_count_monitor.sv
// rtl/cluster_count_monitor.sv - overflow flag/counter and windowed sum readout for cluster counts; CLUSTER_COUNT_MONITOR_PEAK_EN adds win_peak_o
module cluster_count_monitor
  import cluster_count_monitor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int OVF_THRESH = OVF_THRESH_DEF,
  parameter int WIN_LOG2   = WIN_LOG2_DEF,
  parameter int SUM_W      = CNT_W + WIN_LOG2,
  parameter int OVFCNT_W   = OVFCNT_W_DEF,
  parameter int DROP_W     = DROP_W_DEF
) (
  input  logic                clock4x,
  input  logic                reset_n,
  input  logic [CNT_W-1:0]    cnt_i,
  input  logic                cnt_valid_i,
  output logic                overflow_o,
  output logic [OVFCNT_W-1:0] ovf_cnt_o,
  output logic [SUM_W-1:0]    win_sum_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic [DROP_W-1:0]   drop_cnt_o,
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
  output logic [CNT_W-1:0]    win_peak_o,
`endif
  input  logic                ovf_clr_i
);

  localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(OVF_THRESH);

  logic                r_overflow;
  logic [SUM_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_idx;
  logic [SUM_W-1:0]    r_win_sum;
  logic                r_win_valid;
  mon_state_t          r_state;

  logic                w_ovf;
  logic                w_handoff;
  logic                w_drop;
  logic [SUM_W-1:0]    w_final;

  assign w_ovf     = cnt_valid_i && (cnt_i > L_THRESH);
  assign w_handoff = cnt_valid_i && (r_idx == '1);
  assign w_final   = r_acc + SUM_W'(cnt_i);
  // a new result is lost only when the holding register is full and not being read
  assign w_drop    = w_handoff && r_win_valid && !win_ready_i;

  // per-sample overflow flag, one cycle after the sample
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
    end
  end

  // window accumulator; keeps running regardless of readout state
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (cnt_valid_i) begin
      if (w_handoff) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_final;
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  // single-entry result holder: ACCUM means empty, HOLD means a result is pending
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_state     <= ACCUM;
      r_win_valid <= 1'b0;
      r_win_sum   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_handoff) begin
            r_win_sum   <= w_final;
            r_win_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (w_handoff) begin
            if (win_ready_i) begin
              r_win_sum <= w_final;
            end
          end else if (win_ready_i) begin
            r_win_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: begin
          r_state     <= ACCUM;
          r_win_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
  logic [CNT_W-1:0] r_peak;
  logic [CNT_W-1:0] r_win_peak;
  logic [CNT_W-1:0] w_peak_final;

  assign w_peak_final = (cnt_i > r_peak) ? cnt_i : r_peak;

  // running window maximum, restarted at each wrap
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_peak <= '0;
    end else if (cnt_valid_i) begin
      r_peak <= w_handoff ? '0 : w_peak_final;
    end
  end

  // peak capture follows exactly the same load condition as the sum
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_win_peak <= '0;
    end else if (w_handoff && (!r_win_valid || win_ready_i)) begin
      r_win_peak <= w_peak_final;
    end
  end

  assign win_peak_o = r_win_peak;
`endif

  sat_counter #(.WIDTH(OVFCNT_W)) u_ovf_cnt (
    .i_clk    (clock4x),
    .i_resetn (reset_n),
    .i_inc    (w_ovf),
    .i_clr    (ovf_clr_i),
    .o_cnt    (ovf_cnt_o)
  );

  sat_counter #(.WIDTH(DROP_W)) u_drop_cnt (
    .i_clk    (clock4x),
    .i_resetn (reset_n),
    .i_inc    (w_drop),
    .i_clr    (ovf_clr_i),
    .o_cnt    (drop_cnt_o)
  );

  assign overflow_o  = r_overflow;
  assign win_sum_o   = r_win_sum;
  assign win_valid_o = r_win_valid;

endmodule

// File: tb/tb_cluster_count_monitor.sv
// tb/tb_cluster_count_monitor.sv - directed self-checking bench for cluster_count_monitor
module tb_cluster_count_monitor;

  localparam int CNT_W    = 11;
  localparam int WIN_LOG2 = 2;
  localparam int SUM_W    = CNT_W + WIN_LOG2;
  localparam int OVFCNT_W = 4;
  localparam int DROP_W   = 8;
  localparam int WIN_N    = 1 << WIN_LOG2;
  localparam int OVF_MAX  = (1 << OVFCNT_W) - 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                clock4x = 1'b0;
  logic                reset_n = 1'b0;
  logic [CNT_W-1:0]    cnt_i = '0;
  logic                cnt_valid_i = 1'b0;
  logic                win_ready_i = 1'b0;
  logic                ovf_clr_i = 1'b0;
  logic                overflow_o;
  logic [OVFCNT_W-1:0] ovf_cnt_o;
  logic [SUM_W-1:0]    win_sum_o;
  logic                win_valid_o;
  logic [DROP_W-1:0]   drop_cnt_o;
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
  logic [CNT_W-1:0]    win_peak_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock4x = ~clock4x;

  cluster_count_monitor #(
    .WIN_LOG2 (WIN_LOG2),
    .OVFCNT_W (OVFCNT_W),
    .DROP_W   (DROP_W)
  ) dut (
    .clock4x     (clock4x),
    .reset_n     (reset_n),
    .cnt_i       (cnt_i),
    .cnt_valid_i (cnt_valid_i),
    .overflow_o  (overflow_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .win_sum_o   (win_sum_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .drop_cnt_o  (drop_cnt_o),
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
    .win_peak_o  (win_peak_o),
`endif
    .ovf_clr_i   (ovf_clr_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a window is a list of samples, a result is their total
  bit m_live = 0;
  int m_ovf = 0, m_ovfcnt = 0, m_sum = 0, m_valid = 0, m_drop = 0, m_peak = 0;
  int win_q[$];

  always @(posedge clock4x) begin
    int total, pk;
    bit handoff, drop_ev;
    m_live = 1;
    if (!reset_n) begin
      m_ovf = 0; m_ovfcnt = 0; m_sum = 0; m_valid = 0; m_drop = 0; m_peak = 0;
      win_q.delete();
    end else begin
      handoff = 0;
      drop_ev = 0;
      total = 0;
      pk = 0;
      m_ovf = (cnt_valid_i && int'(cnt_i) > 8) ? 1 : 0;
      if (cnt_valid_i) begin
        win_q.push_back(int'(cnt_i));
        if (win_q.size() == WIN_N) begin
          handoff = 1;
          foreach (win_q[k]) begin
            total += win_q[k];
            if (win_q[k] > pk) pk = win_q[k];
          end
          win_q.delete();
        end
      end
      if (handoff) begin
        if (!m_valid || win_ready_i) begin
          m_sum = total;
          m_peak = pk;
          m_valid = 1;
        end else begin
          drop_ev = 1;
        end
      end else if (m_valid && win_ready_i) begin
        m_valid = 0;
      end
      if (ovf_clr_i) begin
        m_ovfcnt = 0;
        m_drop = 0;
      end else begin
        if (m_ovf && m_ovfcnt < OVF_MAX) m_ovfcnt++;
        if (drop_ev && m_drop < DROP_MAX) m_drop++;
      end
    end
  end

  always @(negedge clock4x) begin
    if (m_live) begin
      chk("m_overflow", 32'(overflow_o), m_ovf);
      chk("m_ovf_cnt", 32'(ovf_cnt_o), m_ovfcnt);
      chk("m_win_valid", 32'(win_valid_o), m_valid);
      chk("m_win_sum", 32'(win_sum_o), m_sum);
      chk("m_drop_cnt", 32'(drop_cnt_o), m_drop);
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
      chk("m_win_peak", 32'(win_peak_o), m_peak);
`endif
    end
  end

  task automatic step(input bit v, input int c, input bit rdy = 0, input bit clr = 0);
    cnt_valid_i = v;
    cnt_i = CNT_W'(c);
    win_ready_i = rdy;
    ovf_clr_i = clr;
    @(negedge clock4x);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step(0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    // 1: reset with busy inputs
    reset_n = 1'b0;
    repeat (3) step(1, int'($urandom_range(0, 1536)));
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_ovf_cnt", 32'(ovf_cnt_o), 0);
    chk("rst_win_valid", 32'(win_valid_o), 0);
    chk("rst_win_sum", 32'(win_sum_o), 0);
    chk("rst_drop_cnt", 32'(drop_cnt_o), 0);
    reset_n = 1'b1;
    step(1, 100);
    chk("first_overflow", 32'(overflow_o), 1);

    // 2: overflow flag, threshold boundary, dominant clear
    pulse_reset();
    step(1, 8);    chk("ovf_8", 32'(overflow_o), 0);
    step(1, 9);    chk("ovf_9", 32'(overflow_o), 1);
    step(1, 0);    chk("ovf_0", 32'(overflow_o), 0);
    step(1, 1536); chk("ovf_1536", 32'(overflow_o), 1);
    chk("ovf_cnt_2", 32'(ovf_cnt_o), 2);
    step(1, 1000, 0, 1);
    chk("ovf_clr_flag", 32'(overflow_o), 1);
    chk("ovf_clr_cnt", 32'(ovf_cnt_o), 0);

    // 3: window sum with gaps
    pulse_reset();
    step(1, 5); step(0, 99);
    step(1, 7); step(0, 99); step(0, 99);
    step(1, 3); step(0, 99);
    chk("gap_not_valid", 32'(win_valid_o), 0);
    step(1, 1536);
    chk("gap_valid", 32'(win_valid_o), 1);
    chk("gap_sum", 32'(win_sum_o), 1551);

    // 4: backpressure drop
    pulse_reset();
    repeat (4) step(1, 10);
    chk("bp_sum1", 32'(win_sum_o), 40);
    repeat (4) step(1, 10);
    chk("bp_drop", 32'(drop_cnt_o), 1);
    chk("bp_sum_hold", 32'(win_sum_o), 40);
    chk("bp_still_valid", 32'(win_valid_o), 1);
    step(0, 0, 1);
    chk("bp_accept", 32'(win_valid_o), 0);

    // 5: back-to-back accept
    repeat (4) step(1, 2);
    chk("b2b_first", 32'(win_sum_o), 8);
    repeat (3) step(1, 1);
    step(1, 1, 1);
    chk("b2b_valid", 32'(win_valid_o), 1);
    chk("b2b_sum", 32'(win_sum_o), 4);
    chk("b2b_drop", 32'(drop_cnt_o), 1);
    step(0, 0, 1);
    chk("b2b_empty", 32'(win_valid_o), 0);

    // 6: saturation, clear of drops, reset mid-window
    pulse_reset();
    repeat (20) step(1, 100);
    chk("sat_ovf", 32'(ovf_cnt_o), 15);
    chk("sat_drops", 32'(drop_cnt_o), 4);
    step(0, 0, 0, 1);
    chk("clr_drop", 32'(drop_cnt_o), 0);
    chk("clr_keeps_win", 32'(win_valid_o), 1);
    pulse_reset();
    step(1, 50); step(1, 60);
    pulse_reset();
    step(1, 3); step(1, 4); step(1, 5);
    chk("midrst_pending", 32'(win_valid_o), 0);
    step(1, 6);
    chk("midrst_sum", 32'(win_sum_o), 18);
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
    chk("midrst_peak", 32'(win_peak_o), 6);
`endif
    step(0, 0, 1);
    step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_count_monitor.md
Name: cluster_count_monitor

Overview:
- Consumer end of the cluster-count interface: takes the registered per-sample cluster count (0..1536) produced by the cluster counter in the `clock4x` domain.
- Performs four jobs:
  - registers an overflow flag per sample;
  - keeps a saturating overflow-event counter;
  - accumulates counts over a fixed window of valid samples;
  - presents each window sum to readout through a valid/ready handshake.
- Sits between the cluster packer front end and the slow-control/monitoring readout.

Parameters:
- CNT_W, 11, width of incoming count (max 1536).
- OVF_THRESH, 8, sample overflows when count > OVF_THRESH.
- WIN_LOG2, 10, window length = 2^WIN_LOG2 valid samples.
- SUM_W, CNT_W+WIN_LOG2, window sum width; cannot overflow.
- OVFCNT_W, 16, overflow-event counter width.
- DROP_W, 8, dropped-window counter width.

Ports:
- clock4x  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- cnt_i  in  CNT_W  cluster count sample.
- cnt_valid_i  in  1  cnt_i valid this cycle.
- overflow_o  out  1  registered: cnt_i > OVF_THRESH, qualified by cnt_valid_i.
- ovf_cnt_o  out  OVFCNT_W  saturating count of overflow samples.
- win_sum_o  out  SUM_W  completed window sum.
- win_valid_o  out  1  win_sum_o holds an unread result.
- win_ready_i  in  1  readout accepts win_sum_o.
- drop_cnt_o  out  DROP_W  saturating count of windows lost due to backpressure.
- ovf_clr_i  in  1  clear ovf_cnt_o and drop_cnt_o.

Behaviour:
- Reset:
  - Applied when reset_n = 0 at a clock4x edge.
  - All outputs go to 0; accumulator and sample index go to 0; FSM goes to ACCUM.
  - Reset mid-window discards the partial sum.
  - Reset while win_valid_o = 1 discards the pending result.
- Overflow path, latency 1:
  - overflow_o <= cnt_valid_i & (cnt_i > OVF_THRESH).
  - ovf_cnt_o increments by 1 when that condition holds and stops at 2^OVFCNT_W-1.
- ovf_clr_i:
  - Takes priority over a same-cycle increment of ovf_cnt_o and of drop_cnt_o: both counters become 0.
  - Does not touch the window path.
- Window accumulator:
  - acc is SUM_W bits; idx is WIN_LOG2 bits.
  - On a valid sample with idx < 2^WIN_LOG2-1: acc += cnt_i, idx += 1.
  - On a valid sample with idx = 2^WIN_LOG2-1: final = acc + cnt_i; acc <= 0; idx <= 0 (wrap); final is offered to the output stage in the same cycle.
  - Invalid cycles leave acc and idx unchanged.
- Output stage, single-entry holding register:
  - On handoff, if win_valid_o = 0, or if win_valid_o = 1 and win_ready_i = 1 this cycle: win_sum_o <= final, win_valid_o <= 1.
  - Otherwise the new result is dropped: win_sum_o keeps its old value and drop_cnt_o increments, saturating.
  - Without a handoff, win_valid_o & win_ready_i clears win_valid_o; win_sum_o holds its value.
  - win_sum_o is stable while win_valid_o = 1 and win_ready_i = 0.
  - win_ready_i is ignored while win_valid_o = 0.
- FSM:
  - ACCUM: idle/counting; stays here while win_valid_o = 0.
  - HOLD: a result is pending.
  - ACCUM -> HOLD on handoff.
  - HOLD -> ACCUM on accept with no simultaneous handoff.
  - HOLD -> HOLD on accept plus simultaneous handoff (back-to-back), or on drop.
  - Accumulation continues in both states; the window never stalls.
- Latency:
  - overflow_o: 1 cycle after the sample.
  - win_valid_o: rises 1 cycle after the final sample of the window.

Optional Feature:
- Macro: CLUSTER_COUNT_MONITOR_PEAK_EN.
- Defined:
  - Adds output win_peak_o [CNT_W-1:0]: maximum valid cnt_i within the window, including the final sample.
  - Captured alongside win_sum_o under identical handshake and drop rules.
  - Running peak resets to 0 at window wrap and at reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package cluster_count_monitor_pkg:
  - parameter defaults: CNT_W, OVF_THRESH, WIN_LOG2, OVFCNT_W, DROP_W;
  - derived SUM_W;
  - FSM state enumeration {ACCUM, HOLD}.
- Sub-module sat_counter (width parameter; inc/clr inputs, clr dominant), instantiated for ovf_cnt_o and drop_cnt_o.

Test Plan:
1. Reset values: reset_n = 0 for 3 cycles with random cnt_i and cnt_valid_i = 1 -> every output is 0. Release reset -> overflow_o follows the first sample 1 cycle later.
2. Overflow flag and clear: drive cnt_i = 8, 9, 0, 1536 with valid, then ovf_clr_i with a same-cycle overflow sample.
   - overflow_o = 0, 1, 0, 1.
   - ovf_cnt_o = 2, then 0 in the clear cycle (clear dominant).
3. Window sum and gaps: WIN_LOG2 = 2; samples 5, 7, 3, 1536 with valid gaps between them.
   - win_valid_o rises 1 cycle after the 4th valid sample; win_sum_o = 1551.
   - The gaps do not alter the sum.
4. Backpressure drop: WIN_LOG2 = 2, win_ready_i = 0, two full windows of 10s.
   - First result 40 is held; second window dropped; drop_cnt_o = 1; win_sum_o stays 40.
   - Then win_ready_i = 1 -> win_valid_o falls.
5. Back-to-back accept: win_ready_i = 1 in the same cycle as the next window completes with sum 4 -> win_valid_o stays 1, win_sum_o = 4, drop_cnt_o unchanged.
6. Saturation and reset mid-window: OVFCNT_W = 4; 20 overflow samples -> ovf_cnt_o = 15. Pulse reset after 2 of 4 window samples -> next result sums only post-reset samples.
